// File: rtl/conv_dmem_ctrl.sv
// conv_dmem_ctrl
// Word-addressed local data memory (IFM, weights, OFM) with a burst
// controller serving the conv2D accelerator's read and write channels.
// One burst is active at a time; the array is single-ported.
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   req_read_addr/_valid/_ready    read burst request (start word address)
//   req_read_len                   read burst length in beats
//   resp_read_data/_valid/_ready   read beat stream
//   req_write_addr/_valid/_ready   write burst request (start word address)
//   req_write_len                  write burst length in beats
//   req_write_data/_valid/_ready   write beat stream
//   resp_write_status/_valid/_ready  1 = every beat in range, 0 = some beat wrapped
module conv_dmem_ctrl #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] req_read_addr,
  input  logic              req_read_addr_valid,
  output logic              req_read_addr_ready,
  input  logic [31:0]       req_read_len,
  output logic [DWIDTH-1:0] resp_read_data,
  output logic              resp_read_data_valid,
  input  logic              resp_read_data_ready,
  input  logic [AWIDTH-1:0] req_write_addr,
  input  logic              req_write_addr_valid,
  output logic              req_write_addr_ready,
  input  logic [31:0]       req_write_len,
  input  logic [DWIDTH-1:0] req_write_data,
  input  logic              req_write_data_valid,
  output logic              req_write_data_ready,
  output logic              resp_write_status,
  output logic              resp_write_status_valid,
  input  logic              resp_write_status_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD      = 2'd1,
    S_WR      = 2'd2,
    S_WR_RESP = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_last_grant_wr;  // 1 = last granted channel was WRITE
  logic [AWIDTH-1:0]   r_base;
  logic [31:0]         r_len;
  logic [31:0]         r_issued;
  logic [31:0]         r_delivered;
  logic [31:0]         r_wcnt;
  logic                r_err;
  logic                r_inflight;       // array read issued last cycle, data in r_mem_q
  logic [DWIDTH-1:0]   r_mem_q;
  logic [DWIDTH-1:0]   r_fifo [0:1];
  logic                r_fifo_wptr;
  logic                r_fifo_rptr;
  logic [1:0]          r_fifo_count;
  logic [DWIDTH-1:0]   r_mem [0:DEPTH-1];

  logic                  w_idle;
  logic                  w_grant_rd;
  logic                  w_grant_wr;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [AWIDTH:0]       w_wr_sum;
  logic [DEPTH_LOG2-1:0] w_wr_addr;
  logic                  w_wr_oor;
  logic                  w_wr_fire;

  // Round-robin: with both channels requesting, grant the one not granted last.
  assign w_idle     = (r_state == S_IDLE);
  assign w_grant_rd = w_idle & req_read_addr_valid  & (~req_write_addr_valid | r_last_grant_wr);
  assign w_grant_wr = w_idle & req_write_addr_valid & (~req_read_addr_valid  | ~r_last_grant_wr);

  assign w_pop = (r_state == S_RD) & (r_fifo_count != 2'd0) & resp_read_data_ready;
  assign w_occ = {1'b0, r_fifo_count} + {2'b00, r_inflight};
  // The slot freed by this cycle's pop counts as free, which keeps one
  // beat per cycle flowing through the 1-cycle array read into the FIFO.
  assign w_issue = (r_state == S_RD) & (r_issued != r_len) & (w_occ < (3'd2 + {2'b00, w_pop}));
  assign w_rd_addr = r_base[DEPTH_LOG2-1:0] + r_issued[DEPTH_LOG2-1:0];

  // Full-width sum so a beat that crosses the top of the array is detectable.
  assign w_wr_sum  = {1'b0, r_base} + (AWIDTH+1)'(r_wcnt);
  assign w_wr_addr = w_wr_sum[DEPTH_LOG2-1:0];
  assign w_wr_oor  = |w_wr_sum[AWIDTH:DEPTH_LOG2];
  assign w_wr_fire = (r_state == S_WR) & req_write_data_valid;

  assign req_read_addr_ready     = w_grant_rd;
  assign req_write_addr_ready    = w_grant_wr;
  assign resp_read_data          = r_fifo[r_fifo_rptr];
  assign resp_read_data_valid    = (r_fifo_count != 2'd0);
  assign req_write_data_ready    = (r_state == S_WR);
  assign resp_write_status_valid = (r_state == S_WR_RESP);
  assign resp_write_status       = (r_state == S_WR_RESP) & ~r_err;

  // Memory array write port and registered read port (contents survive reset).
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[w_wr_addr] <= req_write_data;
    if (w_issue)   r_mem_q <= r_mem[w_rd_addr];
  end

  // Burst controller FSM with read-return FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_last_grant_wr <= 1'b1;
      r_base          <= '0;
      r_len           <= 32'd0;
      r_issued        <= 32'd0;
      r_delivered     <= 32'd0;
      r_wcnt          <= 32'd0;
      r_err           <= 1'b0;
      r_inflight      <= 1'b0;
      r_fifo[0]       <= '0;
      r_fifo[1]       <= '0;
      r_fifo_wptr     <= 1'b0;
      r_fifo_rptr     <= 1'b0;
      r_fifo_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (w_grant_rd) begin
            r_base          <= req_read_addr;
            r_len           <= req_read_len;
            r_issued        <= 32'd0;
            r_delivered     <= 32'd0;
            r_last_grant_wr <= 1'b0;
            r_state         <= S_RD;
          end else if (w_grant_wr) begin
            r_base          <= req_write_addr;
            r_len           <= req_write_len;
            r_wcnt          <= 32'd0;
            r_err           <= 1'b0;
            r_last_grant_wr <= 1'b1;
            r_state         <= (req_write_len == 32'd0) ? S_WR_RESP : S_WR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD: begin
          if (w_issue) r_issued <= r_issued + 32'd1;
          if (r_inflight) begin
            r_fifo[r_fifo_wptr] <= r_mem_q;
            r_fifo_wptr         <= ~r_fifo_wptr;
          end
          if (w_pop) r_fifo_rptr <= ~r_fifo_rptr;
          r_fifo_count <= r_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};
          r_delivered  <= r_delivered + {31'd0, w_pop};
          if ((r_delivered + {31'd0, w_pop}) == r_len) r_state <= S_IDLE;
        end
        S_WR: begin
          if (w_wr_fire) begin
            r_wcnt <= r_wcnt + 32'd1;
            if (w_wr_oor) r_err <= 1'b1;
            if (r_wcnt == (r_len - 32'd1)) r_state <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (resp_write_status_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_dmem_ctrl.sv
module tb_conv_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_read_addr;
  logic        req_read_addr_valid;
  logic        req_read_addr_ready;
  logic [31:0] req_read_len;
  logic [31:0] resp_read_data;
  logic        resp_read_data_valid;
  logic        resp_read_data_ready;
  logic [31:0] req_write_addr;
  logic        req_write_addr_valid;
  logic        req_write_addr_ready;
  logic [31:0] req_write_len;
  logic [31:0] req_write_data;
  logic        req_write_data_valid;
  logic        req_write_data_ready;
  logic        resp_write_status;
  logic        resp_write_status_valid;
  logic        resp_write_status_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_buf [16];
  int          rd_k   [16];
  int          rd_got;
  bit          rd_hold_ok;
  logic [31:0] wr_buf [8];

  always #5 clk = ~clk;

  conv_dmem_ctrl #(.AWIDTH(32), .DWIDTH(32), .DEPTH_LOG2(12)) dut (
    .clk(clk), .rst(rst),
    .req_read_addr(req_read_addr), .req_read_addr_valid(req_read_addr_valid),
    .req_read_addr_ready(req_read_addr_ready), .req_read_len(req_read_len),
    .resp_read_data(resp_read_data), .resp_read_data_valid(resp_read_data_valid),
    .resp_read_data_ready(resp_read_data_ready),
    .req_write_addr(req_write_addr), .req_write_addr_valid(req_write_addr_valid),
    .req_write_addr_ready(req_write_addr_ready), .req_write_len(req_write_len),
    .req_write_data(req_write_data), .req_write_data_valid(req_write_data_valid),
    .req_write_data_ready(req_write_data_ready),
    .resp_write_status(resp_write_status), .resp_write_status_valid(resp_write_status_valid),
    .resp_write_status_ready(resp_write_status_ready)
  );

  // Each task starts and ends 1 time unit after a rising edge.
  task automatic rd_req(input logic [31:0] a, input logic [31:0] l, output bit ok);
    ok = 1'b0;
    req_read_addr = a; req_read_len = l; req_read_addr_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_read_addr_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_read_addr_valid = 1'b0;
  endtask

  task automatic wr_req(input logic [31:0] a, input logic [31:0] l, output bit ok);
    ok = 1'b0;
    req_write_addr = a; req_write_len = l; req_write_addr_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_write_addr_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_write_addr_valid = 1'b0;
  endtask

  // Cycle k=0 is the first cycle after the address handshake edge.
  task automatic rd_collect(input int n, input bit bp);
    int k = 0;
    bit stall = 1'b0;
    logic [31:0] sd = 32'd0;
    rd_got = 0; rd_hold_ok = 1'b1;
    while (rd_got < n && k < 100) begin
      resp_read_data_ready = bp ? ((k % 3) == 0) : 1'b1;
      #1;
      if (stall && (!resp_read_data_valid || resp_read_data !== sd)) rd_hold_ok = 1'b0;
      if (resp_read_data_valid && resp_read_data_ready) begin
        rd_buf[rd_got] = resp_read_data; rd_k[rd_got] = k; rd_got++; stall = 1'b0;
      end else begin
        stall = resp_read_data_valid; sd = resp_read_data;
      end
      @(posedge clk); #1; k++;
    end
    resp_read_data_ready = 1'b0;
  endtask

  task automatic wr_beats(input int n, output int cyc);
    bit done;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      req_write_data_valid = 1'b1; req_write_data = wr_buf[i]; done = 1'b0;
      while (!done && cyc < 50) begin
        #1;
        done = req_write_data_ready;
        @(posedge clk); #1; cyc++;
      end
    end
    req_write_data_valid = 1'b0;
  endtask

  task automatic wr_status(output bit st, output int wk, output bit ok);
    ok = 1'b0; wk = 0; st = 1'b0;
    while (!ok && wk < 50) begin
      #1;
      if (resp_write_status_valid) begin
        st = resp_write_status; ok = 1'b1; resp_write_status_ready = 1'b1;
      end
      @(posedge clk); #1;
      resp_write_status_ready = 1'b0;
      if (!ok) wk++;
    end
  endtask

  task automatic test_reset();
    logic [6:0] v;
    rst = 1'b0;
    #3;
    v = {req_read_addr_ready, req_write_addr_ready, resp_read_data_valid,
         req_write_data_ready, resp_write_status, resp_write_status_valid, |resp_read_data};
    checks++;
    if (v !== 7'd0) begin errors++; $display("FAIL reset_outputs: got %b expected 0000000", v); end
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    v = {req_read_addr_ready, req_write_addr_ready, resp_read_data_valid,
         req_write_data_ready, resp_write_status, resp_write_status_valid, |resp_read_data};
    checks++;
    if (v !== 7'd0) begin errors++; $display("FAIL idle_outputs: got %b expected 0000000", v); end
  endtask

  task automatic test_write_read();
    bit ok, st; int cyc, wk;
    logic [31:0] exp [4];
    exp[0] = 32'hA0A0_0001; exp[1] = 32'hB0B0_0002; exp[2] = 32'hC0C0_0003; exp[3] = 32'hD0D0_0004;
    for (int i = 0; i < 4; i++) wr_buf[i] = exp[i];
    wr_req(32'h10, 32'd4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr1_addr_hs: got 0 expected 1"); end
    wr_beats(4, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL wr1_beat_cycles: got %0d expected 4", cyc); end
    wr_status(st, wk, ok);
    checks++; if (!ok || wk !== 0 || st !== 1'b1) begin errors++; $display("FAIL wr1_status: got ok=%0d wait=%0d st=%0d expected 1 0 1", ok, wk, st); end
    rd_req(32'h10, 32'd4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd1_addr_hs: got 0 expected 1"); end
    rd_collect(4, 1'b0);
    checks++; if (rd_got !== 4) begin errors++; $display("FAIL rd1_count: got %0d expected 4", rd_got); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_buf[i] !== exp[i] || rd_k[i] !== i + 2) begin
        errors++; $display("FAIL rd1_beat%0d: got %h at cycle %0d expected %h at cycle %0d", i, rd_buf[i], rd_k[i], exp[i], i + 2);
      end
    end
    #1; checks++;
    if (resp_read_data_valid !== 1'b0) begin errors++; $display("FAIL rd1_no_extra: got valid=1 expected 0"); end
  endtask

  task automatic test_backpressure();
    bit ok, st; int cyc, wk;
    for (int i = 0; i < 8; i++) wr_buf[i] = 32'h0B00_0000 + i;
    wr_req(32'h100, 32'd8, ok);
    wr_beats(8, cyc);
    wr_status(st, wk, ok);
    checks++; if (!ok || st !== 1'b1) begin errors++; $display("FAIL bp_wr_status: got ok=%0d st=%0d expected 1 1", ok, st); end
    rd_req(32'h100, 32'd8, ok);
    rd_collect(8, 1'b1);
    checks++; if (rd_got !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", rd_got); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_buf[i] !== 32'h0B00_0000 + i) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, rd_buf[i], 32'h0B00_0000 + i); end
    end
    checks++; if (!rd_hold_ok) begin errors++; $display("FAIL bp_hold: got valid/data change under stall expected stable"); end
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (resp_read_data_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup%0d: got valid=1 expected 0", i); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arbitration();
    bit ok, st; int cyc, wk;
    rst = 1'b0; @(posedge clk); #1; @(posedge clk); #1; rst = 1'b1; @(posedge clk); #1;
    req_read_addr = 32'h10; req_read_len = 32'd1; req_read_addr_valid = 1'b1;
    req_write_addr = 32'h200; req_write_len = 32'd1; req_write_addr_valid = 1'b1;
    #1; checks++;
    if ({req_read_addr_ready, req_write_addr_ready} !== 2'b10) begin
      errors++; $display("FAIL arb_first: got rd/wr ready=%b expected 10", {req_read_addr_ready, req_write_addr_ready});
    end
    @(posedge clk); #1;
    req_read_addr_valid = 1'b0;
    rd_collect(1, 1'b0);
    checks++; if (rd_got !== 1 || rd_buf[0] !== 32'hA0A0_0001) begin errors++; $display("FAIL arb_rd_data: got %h expected a0a00001", rd_buf[0]); end
    req_read_addr_valid = 1'b1;
    #1; checks++;
    if ({req_read_addr_ready, req_write_addr_ready} !== 2'b01) begin
      errors++; $display("FAIL arb_second: got rd/wr ready=%b expected 01", {req_read_addr_ready, req_write_addr_ready});
    end
    @(posedge clk); #1;
    req_read_addr_valid = 1'b0; req_write_addr_valid = 1'b0;
    wr_buf[0] = 32'h0000_0055;
    wr_beats(1, cyc);
    wr_status(st, wk, ok);
    checks++; if (!ok || st !== 1'b1) begin errors++; $display("FAIL arb_wr_status: got ok=%0d st=%0d expected 1 1", ok, st); end
  endtask

  task automatic test_wrap();
    bit ok, st; int cyc, wk;
    wr_buf[0] = 32'hE000_0001; wr_buf[1] = 32'hE000_0002; wr_buf[2] = 32'hE000_0003; wr_buf[3] = 32'hE000_0004;
    wr_req(32'd4094, 32'd4, ok);
    wr_beats(4, cyc);
    wr_status(st, wk, ok);
    checks++; if (!ok || st !== 1'b0) begin errors++; $display("FAIL wrap_status: got ok=%0d st=%0d expected 1 0", ok, st); end
    rd_req(32'd4095, 32'd2, ok);
    rd_collect(2, 1'b0);
    checks++;
    if (rd_got !== 2 || rd_buf[0] !== 32'hE000_0002 || rd_buf[1] !== 32'hE000_0003) begin
      errors++; $display("FAIL wrap_rd_4095: got %h %h expected e0000002 e0000003", rd_buf[0], rd_buf[1]);
    end
    rd_req(32'd0, 32'd2, ok);
    rd_collect(2, 1'b0);
    checks++;
    if (rd_got !== 2 || rd_buf[0] !== 32'hE000_0003 || rd_buf[1] !== 32'hE000_0004) begin
      errors++; $display("FAIL wrap_rd_0: got %h %h expected e0000003 e0000004", rd_buf[0], rd_buf[1]);
    end
  endtask

  task automatic test_zero_len();
    bit ok, st, seen; int wk;
    rd_req(32'h10, 32'd0, ok);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (resp_read_data_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (!ok || seen) begin errors++; $display("FAIL zero_rd: got ok=%0d beat_seen=%0d expected 1 0", ok, seen); end
    wr_req(32'h300, 32'd0, ok);
    wr_status(st, wk, ok);
    checks++; if (!ok || wk !== 0 || st !== 1'b1) begin errors++; $display("FAIL zero_wr_status: got ok=%0d wait=%0d st=%0d expected 1 0 1", ok, wk, st); end
    req_read_addr_valid = 1'b1; req_read_len = 32'd0;
    #1; checks++;
    if (req_read_addr_ready !== 1'b1) begin errors++; $display("FAIL zero_idle: got ready=%b expected 1", req_read_addr_ready); end
    @(posedge clk); #1;
    req_read_addr_valid = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok, st; int cyc, wk;
    for (int i = 0; i < 6; i++) wr_buf[i] = 32'h0C00_0000 + i;
    wr_req(32'h40, 32'd6, ok);
    wr_beats(6, cyc);
    wr_status(st, wk, ok);
    rd_req(32'h40, 32'd6, ok);
    rd_collect(2, 1'b0);
    #1; checks++;
    if (resp_read_data_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got valid=%b expected 1", resp_read_data_valid); end
    rst = 1'b0;
    #1; checks++;
    if ({resp_read_data_valid, resp_write_status_valid, req_write_data_ready} !== 3'b000) begin
      errors++; $display("FAIL rstmid_drop: got %b expected 000", {resp_read_data_valid, resp_write_status_valid, req_write_data_ready});
    end
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rd_req(32'h40, 32'd6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle: got 0 expected 1"); end
    rd_collect(6, 1'b0);
    checks++; if (rd_got !== 6 || rd_k[0] !== 2) begin errors++; $display("FAIL rstmid_count: got %0d first=%0d expected 6 2", rd_got, rd_k[0]); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rd_buf[i] !== 32'h0C00_0000 + i) begin errors++; $display("FAIL rstmid_beat%0d: got %h expected %h", i, rd_buf[i], 32'h0C00_0000 + i); end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_read_addr = 32'd0; req_read_addr_valid = 1'b0; req_read_len = 32'd0;
    resp_read_data_ready = 1'b0;
    req_write_addr = 32'd0; req_write_addr_valid = 1'b0; req_write_len = 32'd0;
    req_write_data = 32'd0; req_write_data_valid = 1'b0;
    resp_write_status_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_backpressure();
    test_arbitration();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
